// File: rtl/byte_assembler.sv
// Serial-to-parallel byte assembler with a one-entry valid/ready output buffer.
// Define PARITY_CHECK_EN for 9-bit frames whose last bit is even parity over the data.
module byte_assembler #(
   parameter int LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   input  logic       abort,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       parity_err,
   output logic [3:0] bit_count
);

`ifdef PARITY_CHECK_EN
   localparam logic [3:0] LAST_IDX = 4'd8;
`else
   localparam logic [3:0] LAST_IDX = 4'd7;
`endif

   logic [3:0] count_q, count_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] out_q, out_d;
   logic       valid_q, valid_d;
   logic       perr_q, perr_d;

   logic [7:0] shift_in;
   logic [7:0] frame_data;
   logic       frame_perr;
   logic       at_last;
   logic       accept;
   logic       complete;
   logic       consume;

   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign shift_in = {bit_in, shift_q[7:1]};
      end else begin : g_msb_first
         assign shift_in = {shift_q[6:0], bit_in};
      end
   endgenerate

`ifdef PARITY_CHECK_EN
   // The parity bit completes the frame but never enters the data shifter.
   assign frame_data = shift_q;
   assign frame_perr = (^shift_q) ^ bit_in;
`else
   logic unused_shift_bits;
   assign unused_shift_bits = ^shift_q;
   assign frame_data        = shift_in;
   assign frame_perr        = 1'b0;
`endif

   assign at_last   = (count_q == LAST_IDX);
   // Stall only the completing bit, and only while the buffer cannot take it.
   assign bit_ready = !(at_last && valid_q && !byte_ready);
   assign accept    = bit_valid && bit_ready;
   assign complete  = accept && at_last && !abort;
   assign consume   = valid_q && byte_ready;

   always_comb begin
      count_d = count_q;
      shift_d = shift_q;
      out_d   = out_q;
      valid_d = valid_q;
      perr_d  = perr_q;

      if (abort) begin
         count_d = 4'd0;
         shift_d = 8'h00;
      end else if (accept) begin
         if (at_last) begin
            count_d = 4'd0;
            shift_d = 8'h00;
         end else begin
            count_d = count_q + 4'd1;
            shift_d = shift_in;
         end
      end

      if (complete) begin
         out_d   = frame_data;
         perr_d  = frame_perr;
         valid_d = 1'b1;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 4'd0;
         shift_q <= 8'h00;
         out_q   <= 8'h00;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         shift_q <= shift_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
      end
   end

   assign byte_out   = out_q;
   assign byte_valid = valid_q;
   assign parity_err = perr_q;
   assign bit_count  = count_q;

endmodule

// File: tb/tb_byte_assembler.sv
// Self-checking bench for byte_assembler: directed scenarios plus random traffic
// against a frame-queue reference model, covering both bit orders at once.
module tb_byte_assembler;

`ifdef PARITY_CHECK_EN
   localparam int N = 9;
`else
   localparam int N = 8;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       abort = 1'b0;
   logic       byte_ready = 1'b0;

   logic       bit_ready_a, byte_valid_a, parity_err_a;
   logic [7:0] byte_out_a;
   logic [3:0] bit_count_a;
   logic       bit_ready_b, byte_valid_b, parity_err_b;
   logic [7:0] byte_out_b;
   logic [3:0] bit_count_b;

   byte_assembler #(.LSB_FIRST(1)) dut (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready_a), .abort(abort), .byte_out(byte_out_a),
      .byte_valid(byte_valid_a), .byte_ready(byte_ready),
      .parity_err(parity_err_a), .bit_count(bit_count_a)
   );

   byte_assembler #(.LSB_FIRST(0)) dut_msb (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready_b), .abort(abort), .byte_out(byte_out_b),
      .byte_valid(byte_valid_b), .byte_ready(byte_ready),
      .parity_err(parity_err_b), .bit_count(bit_count_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: accepted bits of the current frame, plus the pending byte.
   int         frame_q[$];
   logic       m_valid = 1'b0;
   logic [7:0] m_byte_l = 8'h00;
   logic [7:0] m_byte_m = 8'h00;
   logic       m_perr = 1'b0;

   logic       obs_ready, obs_valid, obs_perr;
   logic [7:0] obs_byte, obs_byte_b;
   logic [3:0] obs_count;
   logic       acc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, compare outputs with the model, advance the model.
   task automatic step(input logic rst, input logic bv, input logic bi,
                       input logic ab, input logic br, output logic accepted);
      logic       exp_ready;
      logic       complete;
      logic       p;
      logic [7:0] bl, bm;
      @(negedge clk);
      reset = rst; bit_valid = bv; bit_in = bi; abort = ab; byte_ready = br;
      #1;
      exp_ready = !((frame_q.size() == N - 1) && m_valid && !br);
      check_eq("bit_ready", bit_ready_a, exp_ready);
      check_eq("bit_ready_msb", bit_ready_b, exp_ready);
      check_eq("bit_count", bit_count_a, frame_q.size());
      check_eq("bit_count_msb", bit_count_b, frame_q.size());
      check_eq("byte_valid", byte_valid_a, m_valid);
      check_eq("byte_valid_msb", byte_valid_b, m_valid);
      if (m_valid) begin
         check_eq("byte_out", byte_out_a, m_byte_l);
         check_eq("byte_out_msb", byte_out_b, m_byte_m);
         check_eq("parity_err", parity_err_a, m_perr);
         check_eq("parity_err_msb", parity_err_b, m_perr);
      end
      obs_ready = bit_ready_a; obs_valid = byte_valid_a; obs_perr = parity_err_a;
      obs_byte = byte_out_a; obs_byte_b = byte_out_b; obs_count = bit_count_a;

      complete = 1'b0;
      accepted = 1'b0;
      if (rst) begin
         frame_q.delete();
         m_valid = 1'b0; m_byte_l = 8'h00; m_byte_m = 8'h00; m_perr = 1'b0;
      end else begin
         if (ab) begin
            frame_q.delete();
         end else if (bv && exp_ready) begin
            accepted = 1'b1;
            frame_q.push_back(int'(bi));
            if (frame_q.size() == N) begin
               p = 1'b0;
               for (int i = 0; i < 8; i++) begin
                  bl[i]     = frame_q[i][0];
                  bm[7 - i] = frame_q[i][0];
               end
               for (int i = 0; i < N; i++) p = p ^ frame_q[i][0];
               m_byte_l = bl;
               m_byte_m = bm;
               m_perr   = (N == 9) ? p : 1'b0;
               complete = 1'b1;
               frame_q.delete();
            end
         end
         if (complete) m_valid = 1'b1;
         else if (m_valid && br) m_valid = 1'b0;
      end
   endtask

   task automatic idle(input logic br);
      logic a;
      step(1'b0, 1'b0, 1'b0, 1'b0, br, a);
   endtask

   // Send the first nbits of a frame, retrying each bit until accepted (bounded).
   task automatic send_bits(input logic [7:0] data, input logic pbit, input logic lsb_order,
                            input logic br, input int nbits);
      logic b;
      logic a;
      int   tries;
      for (int i = 0; i < nbits; i++) begin
         b = (i >= 8) ? pbit : (lsb_order ? data[i] : data[7 - i]);
         a = 1'b0;
         tries = 0;
         while (!a && tries < 50) begin
            step(1'b0, 1'b1, b, 1'b0, br, a);
            tries++;
         end
         if (!a) check_eq("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin
      logic [7:0] ff = 8'hFF;
      logic       last_ff;

      repeat (2) @(posedge clk);

      // Reset state
      idle(1'b0);
      check_eq("rst_valid", obs_valid, 0);
      check_eq("rst_byte", obs_byte, 8'h00);
      check_eq("rst_count", obs_count, 0);
      check_eq("rst_ready", obs_ready, 1);
      check_eq("rst_perr", obs_perr, 0);

      // LSB-first A5, consumed immediately
      send_bits(8'hA5, ^8'hA5, 1'b1, 1'b1, N);
      idle(1'b1);
      check_eq("a5_valid", obs_valid, 1);
      check_eq("a5_byte", obs_byte, 8'hA5);
      idle(1'b1);
      check_eq("a5_one_cycle", obs_valid, 0);

      // Stream 1,1,0,... : MSB-first instance sees C0
      send_bits(8'hC0, ^8'hC0, 1'b0, 1'b1, N);
      idle(1'b1);
      check_eq("c0_msb_byte", obs_byte_b, 8'hC0);
      idle(1'b1);

      // Backpressure: 3C held, completing bit of FF stalled
      send_bits(8'h3C, ^8'h3C, 1'b1, 1'b0, N);
      send_bits(ff, ^ff, 1'b1, 1'b0, N - 1);
      last_ff = (N == 9) ? ^ff : ff[7];
      repeat (3) step(1'b0, 1'b1, last_ff, 1'b0, 1'b0, acc);
      check_eq("stall_ready", obs_ready, 0);
      check_eq("stall_count", obs_count, N - 1);
      check_eq("stall_byte", obs_byte, 8'h3C);
      step(1'b0, 1'b1, last_ff, 1'b0, 1'b1, acc);
      check_eq("release_ready", obs_ready, 1);
      idle(1'b1);
      check_eq("ff_valid", obs_valid, 1);
      check_eq("ff_byte", obs_byte, 8'hFF);
      idle(1'b1);

      // Abort with a simultaneous bit, pending byte untouched
      send_bits(8'h5A, ^8'h5A, 1'b1, 1'b0, N);
      send_bits(8'h1F, 1'b0, 1'b1, 1'b0, 5);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
      idle(1'b0);
      check_eq("abort_count", obs_count, 0);
      check_eq("abort_valid", obs_valid, 1);
      check_eq("abort_byte", obs_byte, 8'h5A);
      send_bits(8'h01, ^8'h01, 1'b1, 1'b1, N);
      idle(1'b1);
      check_eq("post_abort_byte", obs_byte, 8'h01);
      idle(1'b1);

      // Parity: 07 with wrong then right parity bit
      send_bits(8'h07, 1'b0, 1'b1, 1'b1, N);
      idle(1'b1);
      check_eq("par07_byte", obs_byte, 8'h07);
      check_eq("par07_err", obs_perr, (N == 9) ? 1 : 0);
      send_bits(8'h07, 1'b1, 1'b1, 1'b1, N);
      idle(1'b1);
      check_eq("par07_ok", obs_perr, 0);
      idle(1'b1);

      // Reset with pending byte and partial frame
      send_bits(8'h96, ^8'h96, 1'b1, 1'b0, N);
      send_bits(8'h0F, 1'b0, 1'b1, 1'b0, 4);
      idle(1'b0);
      check_eq("pre_rst_count", obs_count, 4);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      idle(1'b0);
      check_eq("mid_rst_valid", obs_valid, 0);
      check_eq("mid_rst_byte", obs_byte, 8'h00);
      check_eq("mid_rst_count", obs_count, 0);
      check_eq("mid_rst_ready", obs_ready, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 200) == 0, ($urandom % 4) != 0, 1'($urandom),
              ($urandom % 40) == 0, ($urandom % 3) != 0, acc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/byte_assembler.md
BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 Parameter LSB_FIRST, default 1, 1 = first accepted bit lands in byte_out[0], 0 = first accepted bit lands in byte_out[7], SHALL be provided.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high.
REQ-004 bit_in  input  1  serial data bit (single-bit mux output from the upstream select stage).
REQ-005 bit_valid  input  1  bit_in is valid this cycle.
REQ-006 bit_ready  output  1  block accepts bit_in this cycle; a bit is accepted when bit_valid && bit_ready.
REQ-007 abort  input  1  discard any partially assembled frame.
REQ-008 byte_out  output  8  assembled byte, feeds the 8-bit pipeline register input bus.
REQ-009 byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-010 byte_ready  input  1  downstream consumes byte_out when byte_valid && byte_ready.
REQ-011 parity_err  output  1  parity status of the byte on byte_out, valid only while byte_valid = 1.
REQ-012 bit_count  output  4  number of bits of the current frame accepted so far.

Function
REQ-013 Shift register and bit_count SHALL update only on accepted bits; bit_count increments by 1 per accepted bit.
REQ-014 Frame length N SHALL be 8 bits (9 with PARITY_CHECK_EN); bit_count SHALL wrap to 0 on the accepted bit that completes a frame.
REQ-015 On the completing bit, the 8 data bits SHALL load the output buffer; byte_valid SHALL be 1 on the following cycle (latency 1 cycle from the last accepted bit).
REQ-016 byte_out and parity_err SHALL be held stable while byte_valid && !byte_ready.
REQ-017 byte_valid SHALL clear the cycle after a consume unless a new frame completes in the same cycle as the consume; in that case byte_valid stays 1 and the new byte is presented.
REQ-018 bit_ready SHALL be 0 only when bit_count == N-1 and byte_valid && !byte_ready; it is 1 otherwise (no frame overrun possible, no data dropped).
REQ-019 bit_ready MAY depend combinationally on byte_ready; no other combinational input-to-output path is permitted.
REQ-020 abort SHALL zero bit_count and the shift register on the next edge; abort wins over a simultaneous bit accept (bit discarded); abort SHALL NOT affect the output buffer, byte_valid or parity_err.
REQ-021 Bits with bit_valid = 0 SHALL leave all frame state unchanged.

Reset
REQ-022 While reset is high at a clk edge: byte_out = 8'h00, byte_valid = 0, parity_err = 0, bit_count = 0, shift register = 0.
REQ-023 bit_ready SHALL be 1 during and after reset (its blocking condition cannot hold when byte_valid = 0).
REQ-024 Reset mid-frame or with byte_valid = 1 SHALL discard the partial frame and the pending byte; reset has priority over abort and all handshakes.

Configuration
REQ-025 Macro PARITY_CHECK_EN SHALL control parity support.
REQ-026 With PARITY_CHECK_EN defined: N = 9, the 9th accepted bit is even parity over the 8 data bits, and parity_err = 1 with the byte if the XOR of all 9 bits is 1; the parity bit is not stored in byte_out.
REQ-027 Without PARITY_CHECK_EN: N = 8 and parity_err is tied to 0; port list is unchanged.

Verification
REQ-028 LSB_FIRST = 1, no macro, byte_ready = 1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> byte_out = 8'hA5 and byte_valid = 1 for exactly one cycle, one cycle after the 8th bit.
REQ-029 LSB_FIRST = 0, same bit stream -> byte_out = 8'hA5 presented MSB-first equivalent, i.e. 8'hA5 reversed = 8'hA5 (use bits 1,1,0,0,0,0,0,0 -> 8'hC0 as the check).
REQ-030 byte_ready = 0, stream 16 bits (8'h3C then 8'hFF) -> byte_out holds 8'h3C; bit_ready = 0 with bit_count = 7; raising byte_ready consumes 8'h3C, 8th bit accepted, 8'hFF shown next cycle.
REQ-031 Accept 5 bits, assert abort together with a 6th valid bit -> bit_count = 0 next cycle, pending byte_valid/byte_out unchanged; next 8 bits 8'h01 -> byte_out = 8'h01.
REQ-032 PARITY_CHECK_EN, data 8'h07 then parity bit 0 -> byte_out = 8'h07, parity_err = 1; data 8'h07 with parity bit 1 -> parity_err = 0.
REQ-033 Assert reset with byte_valid = 1 and bit_count = 4 -> next cycle byte_valid = 0, byte_out = 8'h00, bit_count = 0, bit_ready = 1.
